// File: rtl/mem_bus_arbiter.sv
// Shares a single-outstanding memory bus port between instruction fetch (IF) and load/store (MEM).
// MEM wins by default; IF is forced through after STARVE_MAX consecutive MEM wins over it.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic                mem_rvalid_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                if_stall_o,
  output logic                mem_stall_o
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_MEM, OWN_IF} owner_t;

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             if_wins;
  logic             resp_fire;

  // IF only wins a contested slot once MEM has beaten it STARVE_MAX times in a row.
  assign if_wins   = if_req_i & (~mem_req_i | (starve_cnt == CNT_MAX));
  assign resp_fire = ~rst & (state == RESP) & bus_rvalid_i;

  assign if_rvalid_o  = resp_fire & (owner == OWN_IF);
  assign mem_rvalid_o = resp_fire & (owner == OWN_MEM);
  assign if_rdata_o   = if_rvalid_o  ? bus_rdata_i : '0;
  assign mem_rdata_o  = mem_rvalid_o ? bus_rdata_i : '0;

  assign if_stall_o  = ~rst & if_req_i  & ~if_rvalid_o;
  assign mem_stall_o = ~rst & mem_req_i & ~mem_rvalid_o;

  // NOTE: registers use non-blocking assignments so every one samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_MEM;
      starve_cnt  <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_wins) begin
            owner       <= OWN_IF;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
            bus_wstrb_o <= '0;
            starve_cnt  <= '0;
          end else if (mem_req_i) begin
            owner       <= OWN_MEM;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_wdata_o <= mem_wdata_i;
            bus_wstrb_o <= mem_wstrb_i;
            if (!if_req_i)
              starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX)
              starve_cnt <= starve_cnt + CNT_W'(1);
          end else begin
            starve_cnt <= '0;
          end
          if (if_req_i | mem_req_i) begin
            bus_req_o <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (bus_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model checked every cycle, plus directed scenarios
// with hand-computed expectations for reset, latency, arbitration order, stalls and reset abort.
module tb_mem_bus_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int STRB_W     = DATA_W / 8;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, mem_req, mem_we, bus_gnt, bus_rvalid;
  logic [ADDR_W-1:0] if_addr, mem_addr;
  logic [DATA_W-1:0] mem_wdata, bus_rdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              if_rvalid, mem_rvalid, bus_req, bus_we, if_stall, mem_stall;
  logic [DATA_W-1:0] if_rdata, mem_rdata, bus_wdata;
  logic [ADDR_W-1:0] bus_addr;
  logic [STRB_W-1:0] bus_wstrb;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_wstrb_i(mem_wstrb), .mem_rvalid_o(mem_rvalid), .mem_rdata_o(mem_rdata),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_wstrb_o(bus_wstrb), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata), .if_stall_o(if_stall), .mem_stall_o(mem_stall)
  );

  typedef struct packed {
    logic              is_if;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } txn_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    int                len;
  } grant_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one transaction in flight; it is either waiting for
  // acceptance or waiting for its response. m_streak counts MEM wins over a waiting IF.
  bit   m_busy = 1'b0, m_acc = 1'b0, m_fresh = 1'b1;
  txn_t m_cur = '0;
  int   m_streak = 0;
  wire  m_if_pick = if_req && (!mem_req || m_streak >= STARVE_MAX);

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_acc <= 1'b0; m_fresh <= 1'b1; m_cur <= '0; m_streak <= 0;
    end else if (!m_busy) begin
      if (if_req || mem_req) begin
        m_busy <= 1'b1; m_acc <= 1'b0; m_fresh <= 1'b0;
        if (m_if_pick) begin
          m_cur    <= '{is_if: 1'b1, we: 1'b0, addr: if_addr, wdata: '0, wstrb: '0};
          m_streak <= 0;
        end else begin
          m_cur    <= '{is_if: 1'b0, we: mem_we, addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
          m_streak <= if_req ? ((m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX) : 0;
        end
      end else begin
        m_streak <= 0;
      end
    end else if (!m_acc) begin
      if (bus_gnt) m_acc <= 1'b1;
    end else if (bus_rvalid) begin
      m_busy <= 1'b0;
    end
  end

  wire e_bus_req = m_busy && !m_acc;
  wire e_resp    = !rst && m_busy && m_acc && bus_rvalid;
  wire e_if_rv   = e_resp && m_cur.is_if;
  wire e_mem_rv  = e_resp && !m_cur.is_if;

  bit     chk_on = 1'b0;
  bit     last_if_rv = 1'b0, last_mem_rv = 1'b0, prev_bus_req = 1'b0;
  grant_t glog[$];

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("bus_req", bus_req, e_bus_req);
      if (e_bus_req || m_fresh) begin
        check("bus_we", bus_we, m_cur.we);
        check("bus_addr", bus_addr, m_cur.addr);
        check("bus_wstrb", bus_wstrb, m_cur.wstrb);
        if (!m_cur.is_if) check("bus_wdata", bus_wdata, m_cur.wdata);
      end
      check("if_rvalid", if_rvalid, e_if_rv);
      check("if_rdata", if_rdata, e_if_rv ? bus_rdata : 64'h0);
      check("mem_rvalid", mem_rvalid, e_mem_rv);
      check("mem_rdata", mem_rdata, e_mem_rv ? bus_rdata : 64'h0);
      check("if_stall", if_stall, !rst && if_req && !e_if_rv);
      check("mem_stall", mem_stall, !rst && mem_req && !e_mem_rv);
      if (bus_req === 1'b1 && !prev_bus_req)
        glog.push_back('{we: bus_we, addr: bus_addr, wdata: bus_wdata, wstrb: bus_wstrb, len: 1});
      else if (bus_req === 1'b1 && glog.size() > 0)
        glog[glog.size()-1].len++;
      prev_bus_req = (bus_req === 1'b1);
      last_if_rv   = e_if_rv;
      last_mem_rv  = e_mem_rv;
    end
  end

  // Reactive requesters (hold req until their rvalid) and a bus that grants after gnt_delay
  // cycles of bus_req and responds in the first RESP cycle.
  logic [ADDR_W-1:0] if_q[$];
  txn_t              mem_q[$];
  int                gnt_delay = 0, req_cycles = 0;
  bit                gnt_taken = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic auto_drive();
    if (last_if_rv && if_q.size() > 0) void'(if_q.pop_front());
    if (last_mem_rv && mem_q.size() > 0) void'(mem_q.pop_front());
    if_req = 1'b0; if_addr = '0;
    if (if_q.size() > 0) begin if_req = 1'b1; if_addr = if_q[0]; end
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    if (mem_q.size() > 0) begin
      mem_req = 1'b1; mem_we = mem_q[0].we; mem_addr = mem_q[0].addr;
      mem_wdata = mem_q[0].wdata; mem_wstrb = mem_q[0].wstrb;
    end
    bus_rvalid = gnt_taken;
    bus_rdata  = gnt_taken ? {32'hD0D0_0000, bus_addr} : '0;
    gnt_taken  = 1'b0;
    bus_gnt    = 1'b0;
    if (bus_req === 1'b1) begin
      if (req_cycles == gnt_delay) begin bus_gnt = 1'b1; gnt_taken = 1'b1; end
      req_cycles++;
    end else begin
      req_cycles = 0;
    end
  endtask

  task automatic run_auto(input int budget, input string name);
    bit done = 1'b0;
    gnt_taken = 1'b0; req_cycles = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      auto_drive();
      done = (if_q.size() == 0 && mem_q.size() == 0 && !m_busy);
    end
    check({name, "_completed"}, done, 1);
  endtask

  logic [ADDR_W-1:0] t3_exp [8];

  initial begin
    rst = 1'b1; if_req = 1'b1; mem_req = 1'b1; if_addr = 32'h44; mem_we = 1'b1;
    mem_addr = 32'h88; mem_wdata = 64'h99; mem_wstrb = 8'hFF;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    tick();
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_if_stall", if_stall, 0);
    check("rst_mem_stall", mem_stall, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_addr", bus_addr, 0);
    tick();
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; if_addr = '0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;

    // 1: IF-only read, gnt in the first REQ cycle, response in the next
    tick(); if_req = 1'b1; if_addr = 32'h8000_0000;
    @(negedge clk);
    check("t1_stall_c1", if_stall, 1);
    check("t1_breq_c1", bus_req, 0);
    tick(); bus_gnt = 1'b1;
    @(negedge clk);
    check("t1_breq_c2", bus_req, 1);
    check("t1_baddr_c2", bus_addr, 64'h8000_0000);
    check("t1_bwe_c2", bus_we, 0);
    check("t1_stall_c2", if_stall, 1);
    tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h13;
    @(negedge clk);
    check("t1_rvalid_c3", if_rvalid, 1);
    check("t1_rdata_c3", if_rdata, 64'h13);
    check("t1_stall_c3", if_stall, 0);
    check("t1_breq_c3", bus_req, 0);
    tick(); bus_rvalid = 1'b0; bus_rdata = '0; if_req = 1'b0; if_addr = '0;
    @(negedge clk);
    check("t1_rvalid_c4", if_rvalid, 0);
    check("t1_rdata_c4", if_rdata, 0);

    // 2: both request; MEM write goes first, IF read after it
    glog.delete();
    mem_q.push_back('{is_if: 1'b0, we: 1'b1, addr: 32'h8000_1000, wdata: 64'hDEAD, wstrb: 8'h0F});
    if_q.push_back(32'h8000_0040);
    run_auto(40, "t2");
    check("t2_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      check("t2_g0_we", glog[0].we, 1);
      check("t2_g0_addr", glog[0].addr, 64'h8000_1000);
      check("t2_g0_wdata", glog[0].wdata, 64'hDEAD);
      check("t2_g0_wstrb", glog[0].wstrb, 8'h0F);
      check("t2_g1_we", glog[1].we, 0);
      check("t2_g1_addr", glog[1].addr, 64'h8000_0040);
    end

    // 3: continuous contention -> M,M,M,M,IF,M,M then the last IF
    glog.delete();
    for (int i = 0; i < 6; i++)
      mem_q.push_back('{is_if: 1'b0, we: 1'b0, addr: 32'h1000 + 32'(i * 8), wdata: '0, wstrb: '0});
    if_q.push_back(32'h2000);
    if_q.push_back(32'h2004);
    t3_exp = '{32'h1000, 32'h1008, 32'h1010, 32'h1018, 32'h2000, 32'h1020, 32'h1028, 32'h2004};
    run_auto(80, "t3");
    check("t3_grants", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      check($sformatf("t3_order%0d", i), glog[i].addr, t3_exp[i]);

    // 4: gnt withheld for 3 cycles -> request and payload held for 4 cycles
    glog.delete();
    gnt_delay = 3;
    mem_q.push_back('{is_if: 1'b0, we: 1'b1, addr: 32'h3000, wdata: 64'h0123_4567_89AB_CDEF, wstrb: 8'hA5});
    run_auto(30, "t4");
    gnt_delay = 0;
    check("t4_grants", glog.size(), 1);
    if (glog.size() >= 1) begin
      check("t4_req_cycles", glog[0].len, 4);
      check("t4_addr", glog[0].addr, 64'h3000);
      check("t4_wdata", glog[0].wdata, 64'h0123_4567_89AB_CDEF);
      check("t4_wstrb", glog[0].wstrb, 8'hA5);
    end

    // 5: rst during RESP, then a stale bus response
    tick(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h4000; mem_wdata = 64'h77; mem_wstrb = 8'hFF;
    tick(); bus_gnt = 1'b1;
    @(negedge clk);
    check("t5_breq", bus_req, 1);
    tick(); bus_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t5_stall_in_rst", mem_stall, 0);
    tick(); rst = 1'b0; mem_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'hFF;
    @(negedge clk);
    check("t5_breq_after", bus_req, 0);
    check("t5_bwe_after", bus_we, 0);
    check("t5_baddr_after", bus_addr, 0);
    check("t5_bwdata_after", bus_wdata, 0);
    check("t5_mem_rvalid", mem_rvalid, 0);
    check("t5_mem_rdata", mem_rdata, 0);
    tick(); bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    check("t5_idle", bus_req, 0);

    // 6: stray gnt/rvalid while idle; then a MEM read whose req drops during REQ
    tick(); bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h55;
    @(negedge clk);
    check("t6_if_rvalid", if_rvalid, 0);
    check("t6_mem_rvalid", mem_rvalid, 0);
    check("t6_mem_rdata", mem_rdata, 0);
    tick(); bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h5000; mem_wdata = '0; mem_wstrb = '0;
    @(negedge clk);
    check("t6_still_idle", bus_req, 0);
    tick(); mem_req = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    check("t7_breq", bus_req, 1);
    check("t7_baddr", bus_addr, 64'h5000);
    tick(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'hABCD;
    @(negedge clk);
    check("t7_rvalid_after_drop", mem_rvalid, 1);
    check("t7_rdata_after_drop", mem_rdata, 64'hABCD);
    tick(); bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    check("t7_rvalid_end", mem_rvalid, 0);
    check("t7_idle_end", bus_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
